csr_unit: RTL and testbench

Machine-mode CSR state for the 64-bit in-order core. It serves two paths:
- Decode reads CSR values through a read port. These become `csr_data` in the decode bundle.
- Writeback commits the `csr_addr`/`csr_data` pair that execute computes for CSRRW/RS/RC(I).

The unit also performs trap entry and MRET state updates, issues a registered PC redirect to fetch, and runs the mcycle/minstret counters.

---
 rtl/csr_unit_if.sv | 31 +++
 rtl/csr_unit.sv | 124 ++++++++++++
 tb/tb_csr_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/csr_unit_if.sv
// rtl/csr_unit_if.sv - Decode read, writeback commit, trap/MRET and redirect bundle for csr_unit.
interface csr_unit_if;
    logic [11:0] rd_addr;
    logic [63:0] rd_data;
    logic        wr_valid;
    logic [11:0] wr_addr;
    logic [63:0] wr_data;
    logic        trap_valid;
    logic [63:0] trap_pc;
    logic [63:0] trap_cause;
    logic [63:0] trap_tval;
    logic        mret_valid;
    logic        instret_inc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [1:0]  priv;

    modport master (
        output rd_addr, wr_valid, wr_addr, wr_data,
        output trap_valid, trap_pc, trap_cause, trap_tval,
        output mret_valid, instret_inc,
        input  rd_data, redirect_valid, redirect_pc, priv
    );

    modport slave (
        input  rd_addr, wr_valid, wr_addr, wr_data,
        input  trap_valid, trap_pc, trap_cause, trap_tval,
        input  mret_valid, instret_inc,
        output rd_data, redirect_valid, redirect_pc, priv
    );
endinterface

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - Machine-mode CSR file with trap entry, MRET, redirect and mcycle/minstret.
module csr_unit #(
    parameter logic [63:0] HARTID = 64'd0
) (
    input  logic       clk,
    input  logic       reset,
    csr_unit_if.slave  bus
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
    localparam logic [63:0] MISA_VAL   = 64'h8000_0000_0000_1100;

    logic        st_mie, st_mpie;
    logic [1:0]  st_mpp;
    logic [63:0] mie_q, mip_q, mscratch_q, mtval_q, mcause_q, mtvec_q, mepc_q;
    logic [63:0] mcycle_q, minstret_q;
    logic [1:0]  priv_q;
    logic        redirect_valid_q;
    logic [63:0] redirect_pc_q;

    logic        mret_en, wr_en;
    logic [63:0] mstatus_val;
    logic        unused_trap_pc0;

    // Trap outranks MRET, which outranks a CSR commit; losers are dropped.
    assign mret_en = bus.mret_valid & ~bus.trap_valid;
    assign wr_en   = bus.wr_valid & ~bus.trap_valid & ~bus.mret_valid;

    assign mstatus_val     = {51'd0, st_mpp, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
    assign unused_trap_pc0 = bus.trap_pc[0];

    always_comb begin
        bus.rd_data = 64'd0;
        case (bus.rd_addr)
            A_MSTATUS:  bus.rd_data = mstatus_val;
            A_MISA:     bus.rd_data = MISA_VAL;
            A_MIE:      bus.rd_data = mie_q;
            A_MTVEC:    bus.rd_data = mtvec_q;
            A_MSCRATCH: bus.rd_data = mscratch_q;
            A_MEPC:     bus.rd_data = mepc_q;
            A_MCAUSE:   bus.rd_data = mcause_q;
            A_MTVAL:    bus.rd_data = mtval_q;
            A_MIP:      bus.rd_data = mip_q;
            A_MCYCLE:   bus.rd_data = mcycle_q;
            A_MINSTRET: bus.rd_data = minstret_q;
            A_MHARTID:  bus.rd_data = HARTID;
            default:    bus.rd_data = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_mie           <= 1'b0;
            st_mpie          <= 1'b0;
            st_mpp           <= 2'b00;
            mie_q            <= 64'd0;
            mip_q            <= 64'd0;
            mscratch_q       <= 64'd0;
            mtval_q          <= 64'd0;
            mcause_q         <= 64'd0;
            mtvec_q          <= 64'd0;
            mepc_q           <= 64'd0;
            mcycle_q         <= 64'd0;
            minstret_q       <= 64'd0;
            priv_q           <= 2'd3;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 64'd0;
        end else begin
            // Counter writes below override these increments by NBA ordering.
            mcycle_q         <= mcycle_q + 64'd1;
            minstret_q       <= minstret_q + {63'd0, bus.instret_inc};
            redirect_valid_q <= bus.trap_valid | bus.mret_valid;

            if (bus.trap_valid) begin
                mepc_q        <= {bus.trap_pc[63:1], 1'b0};
                mcause_q      <= bus.trap_cause;
                mtval_q       <= bus.trap_tval;
                st_mpie       <= st_mie;
                st_mie        <= 1'b0;
                st_mpp        <= priv_q;
                priv_q        <= 2'd3;
                redirect_pc_q <= mtvec_q;
            end else if (mret_en) begin
                priv_q        <= st_mpp;
                st_mie        <= st_mpie;
                st_mpie       <= 1'b1;
                st_mpp        <= 2'b00;
                redirect_pc_q <= mepc_q;
            end else if (wr_en) begin
                case (bus.wr_addr)
                    A_MSTATUS: begin
                        st_mie  <= bus.wr_data[3];
                        st_mpie <= bus.wr_data[7];
                        st_mpp  <= (bus.wr_data[12:11] == 2'b10) ? 2'b00 : bus.wr_data[12:11];
                    end
                    A_MIE:      mie_q      <= bus.wr_data;
                    A_MTVEC:    mtvec_q    <= {bus.wr_data[63:2], 2'b00};
                    A_MSCRATCH: mscratch_q <= bus.wr_data;
                    A_MEPC:     mepc_q     <= {bus.wr_data[63:1], 1'b0};
                    A_MCAUSE:   mcause_q   <= bus.wr_data;
                    A_MTVAL:    mtval_q    <= bus.wr_data;
                    A_MIP:      mip_q      <= bus.wr_data;
                    A_MCYCLE:   mcycle_q   <= bus.wr_data;
                    A_MINSTRET: minstret_q <= bus.wr_data;
                    default: ;
                endcase
            end
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.priv           = priv_q;
endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - Self-checking bench for csr_unit: write/read vector table plus trap/MRET/counter sequences.
`timescale 1ns/100ps
module tb_csr_unit;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   pulses;
    logic [63:0] exp_redirect_q[$];

    csr_unit_if bus();

    csr_unit #(.HARTID(64'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [11:0] waddr;
        logic [63:0] wdata;
        logic [11:0] raddr;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [63:0] exp);
        bus.rd_addr = addr;
        #1;
        chk(name, bus.rd_data, exp);
    endtask

    // Redirect scoreboard: every pulse must match the oldest expected target.
    always @(negedge clk) begin
        if (bus.redirect_valid === 1'b1) begin
            pulses++;
            checks++;
            if (exp_redirect_q.size() == 0) begin
                errors++;
                $display("FAIL redirect_unexpected: got pc %h expected no pulse", bus.redirect_pc);
            end else begin
                logic [63:0] e;
                e = exp_redirect_q.pop_front();
                if (bus.redirect_pc !== e) begin
                    errors++;
                    $display("FAIL redirect_pc: got %h expected %h", bus.redirect_pc, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        errors = 0;
        checks = 0;
        pulses = 0;
        vecs[0]  = '{12'h305, 64'h8000_0103,          12'h305, 64'h8000_0100};
        vecs[1]  = '{12'h341, 64'h1235,               12'h341, 64'h1234};
        vecs[2]  = '{12'h340, 64'hDEAD_BEEF,          12'h340, 64'hDEAD_BEEF};
        vecs[3]  = '{12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 12'h300, 64'h1888};
        vecs[4]  = '{12'h300, 64'h1000,               12'h300, 64'h0};
        vecs[5]  = '{12'h7C0, 64'h5,                  12'h7C0, 64'h0};
        vecs[6]  = '{12'h301, 64'h0,                  12'h301, 64'h8000_0000_0000_1100};
        vecs[7]  = '{12'h304, 64'hAAA,                12'h304, 64'hAAA};
        vecs[8]  = '{12'h343, 64'h1357,               12'h343, 64'h1357};
        vecs[9]  = '{12'hF14, 64'h7,                  12'hF14, 64'h0};
        vecs[10] = '{12'h305, 64'h8000_0100,          12'h305, 64'h8000_0100};
        vecs[11] = '{12'h300, 64'h8,                  12'h300, 64'h8};

        reset = 1'b0;
        bus.rd_addr = 12'h300; bus.wr_valid = 1'b0; bus.wr_addr = 12'h0; bus.wr_data = 64'h0;
        bus.trap_valid = 1'b0; bus.trap_pc = 64'h0; bus.trap_cause = 64'h0; bus.trap_tval = 64'h0;
        bus.mret_valid = 1'b0; bus.instret_inc = 1'b0;
        step(); step();
        chk("reset_priv", {62'd0, bus.priv}, 64'd3);
        chk("reset_redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
        chk("reset_redirect_pc", bus.redirect_pc, 64'd0);

        reset = 1'b1;
        step();
        rd("rst_mstatus", 12'h300, 64'h0);
        rd("rst_mtvec", 12'h305, 64'h0);
        rd("rst_mcycle", 12'hB00, 64'h1);
        rd("rst_mhartid", 12'hF14, 64'h0);

        for (int i = 0; i < 12; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = vecs[i].waddr;
            bus.wr_data  = vecs[i].wdata;
            bus.rd_addr  = vecs[i].raddr;
            step();
            bus.wr_valid = 1'b0;
            rd($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end

        // Trap with MIE=1 from M-mode.
        bus.trap_valid = 1'b1; bus.trap_pc = 64'h8000_1004; bus.trap_cause = 64'd2; bus.trap_tval = 64'h55;
        exp_redirect_q.push_back(64'h8000_0100);
        step();
        bus.trap_valid = 1'b0;
        chk("trap_redirect_valid", {63'd0, bus.redirect_valid}, 64'd1);
        rd("trap_mepc", 12'h341, 64'h8000_1004);
        rd("trap_mcause", 12'h342, 64'd2);
        rd("trap_mtval", 12'h343, 64'h55);
        rd("trap_mstatus", 12'h300, 64'h1880);
        step();
        chk("trap_pulse_drop", {63'd0, bus.redirect_valid}, 64'd0);

        bus.mret_valid = 1'b1;
        exp_redirect_q.push_back(64'h8000_1004);
        step();
        bus.mret_valid = 1'b0;
        rd("mret_mstatus", 12'h300, 64'h88);
        chk("mret_priv", {62'd0, bus.priv}, 64'd3);
        step();

        // Trap then MRET back-to-back.
        bus.trap_valid = 1'b1; bus.trap_pc = 64'h2000;
        exp_redirect_q.push_back(64'h8000_0100);
        step();
        bus.trap_valid = 1'b0; bus.mret_valid = 1'b1;
        exp_redirect_q.push_back(64'h2000);
        step();
        bus.mret_valid = 1'b0;
        step();

        // Trap, MRET and a write all in one cycle: only the trap lands.
        p0 = pulses;
        bus.trap_valid = 1'b1; bus.trap_pc = 64'h3001; bus.mret_valid = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_addr = 12'h340; bus.wr_data = 64'd5;
        exp_redirect_q.push_back(64'h8000_0100);
        step();
        bus.trap_valid = 1'b0; bus.mret_valid = 1'b0; bus.wr_valid = 1'b0;
        step(); step();
        chk("triple_pulses", 64'(pulses - p0), 64'd1);
        rd("triple_mscratch", 12'h340, 64'hDEAD_BEEF);
        rd("triple_mepc", 12'h341, 64'h3000);

        // mtvec write alongside a trap is dropped.
        bus.trap_valid = 1'b1; bus.trap_pc = 64'h3001;
        bus.wr_valid = 1'b1; bus.wr_addr = 12'h305; bus.wr_data = 64'h9000;
        exp_redirect_q.push_back(64'h8000_0100);
        step();
        bus.trap_valid = 1'b0; bus.wr_valid = 1'b0;
        rd("trap_wr_mtvec", 12'h305, 64'h8000_0100);
        step();

        // MRET into U-mode, then trap from U-mode.
        bus.wr_valid = 1'b1; bus.wr_addr = 12'h300; bus.wr_data = 64'h0;
        step();
        bus.wr_valid = 1'b0;
        bus.mret_valid = 1'b1;
        exp_redirect_q.push_back(64'h3000);
        step();
        bus.mret_valid = 1'b0;
        chk("mret_to_user", {62'd0, bus.priv}, 64'd0);
        rd("user_mstatus", 12'h300, 64'h80);
        bus.trap_valid = 1'b1; bus.trap_pc = 64'h4000;
        exp_redirect_q.push_back(64'h8000_0100);
        step();
        bus.trap_valid = 1'b0;
        chk("trap_from_user_priv", {62'd0, bus.priv}, 64'd3);
        rd("trap_from_user_mstatus", 12'h300, 64'h0);
        step();

        // Counters.
        bus.wr_valid = 1'b1; bus.wr_addr = 12'hB00; bus.wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        bus.wr_valid = 1'b0;
        rd("mcycle_max", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        rd("mcycle_wrap", 12'hB00, 64'h0);
        bus.wr_valid = 1'b1; bus.wr_addr = 12'hB02; bus.wr_data = 64'd100;
        step();
        bus.wr_valid = 1'b0;
        bus.instret_inc = 1'b1;
        step(); step(); step();
        bus.instret_inc = 1'b0;
        rd("minstret_plus3", 12'hB02, 64'd103);
        bus.wr_valid = 1'b1; bus.wr_addr = 12'hB02; bus.wr_data = 64'd10; bus.instret_inc = 1'b1;
        step();
        bus.wr_valid = 1'b0; bus.instret_inc = 1'b0;
        rd("minstret_write_wins", 12'hB02, 64'd10);

        // Reset in the same edge as a trap suppresses the redirect.
        reset = 1'b0; bus.trap_valid = 1'b1; bus.trap_pc = 64'h5000;
        step();
        bus.trap_valid = 1'b0;
        chk("midreset_redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
        chk("midreset_redirect_pc", bus.redirect_pc, 64'd0);
        rd("midreset_mepc", 12'h341, 64'h0);
        reset = 1'b1;
        step(); step();

        chk("redirect_queue_empty", 64'(exp_redirect_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
